// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: line-granular memory model behind the data cache.
// Accepts one 256-bit read or write at a time, completes it after a fixed
// LATENCY with a one-cycle ack, and counts completed reads and writes.
module line_mem_ctrl #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wr;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ack;
  logic                r_busy;
  logic [DATA_W-1:0]   r_data_o;
  logic [31:0]         r_rd_cnt;
  logic [31:0]         r_wr_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [IDX_W-1:0]    w_idx;
  logic                w_unused_addr;

  // Line index from the byte address; upper bits alias, low 5 bits are the byte offset.
  assign w_idx         = addr_i[IDX_W+4:5];
  assign w_unused_addr = ^{addr_i[ADDR_W-1:IDX_W+5], addr_i[4:0]};

  assign ack_o    = r_ack;
  assign busy_o   = r_busy;
  assign data_o   = r_data_o;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

  // Request FSM with registered ack/busy/data outputs and saturating counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wr     <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_data_o <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_wr    <= write_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              if (!write_i) r_data_o <= r_mem[w_idx];
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Outputs are registered, so ACK is entered on the edge where the
          // counter steps from 1 to 0 rather than one edge after it reads 0.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (!r_wr) r_data_o <= r_mem[r_idx];
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          if (r_wr) begin
            if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
          end else begin
            if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: written at the edge ending a write ACK; never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_ACK && r_wr) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: directed bench for line_mem_ctrl, two builds
// (LATENCY=10 and LATENCY=1) checked every cycle against a transaction model.
module tb_line_mem_ctrl;

  logic         clk;
  logic         rst;
  logic         en   [2];
  logic         wr   [2];
  logic [31:0]  ad   [2];
  logic [255:0] di   [2];
  logic         ack  [2];
  logic [255:0] dout [2];
  logic         busy [2];
  logic [31:0]  rcnt [2];
  logic [31:0]  wcnt [2];

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  line_mem_ctrl #(.DATA_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .write_i(wr[0]), .addr_i(ad[0]),
    .data_i(di[0]), .ack_o(ack[0]), .data_o(dout[0]), .busy_o(busy[0]),
    .rd_cnt_o(rcnt[0]), .wr_cnt_o(wcnt[0])
  );

  line_mem_ctrl #(.DATA_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .write_i(wr[1]), .addr_i(ad[1]),
    .data_i(di[1]), .ack_o(ack[1]), .data_o(dout[1]), .busy_o(busy[1]),
    .rd_cnt_o(rcnt[1]), .wr_cnt_o(wcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Transaction model: a request accepted at edge E acks in the cycle after
  // edge E+L-1 and commits at edge E+L; nothing is accepted at the commit edge.
  function automatic int lat_of(input int k);
    return (k == 0) ? 10 : 1;
  endfunction

  logic [255:0] mm [int];
  int           cyc = 0;
  bit           pend [2];
  int           acc  [2];
  bit           lw   [2];
  int           li   [2];
  logic [255:0] ld   [2];
  bit           ea   [2];
  bit           eb   [2];
  logic [255:0] ed   [2];
  logic [31:0]  erc  [2];
  logic [31:0]  ewc  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 0; ea[k] = 0; ed[k] = '0; erc[k] = '0; ewc[k] = '0;
      end else begin
        ea[k] = 0;
        if (pend[k] && cyc == acc[k] + lat_of(k)) begin
          pend[k] = 0;
          if (lw[k]) begin
            mm[k * 1024 + li[k]] = ld[k];
            if (ewc[k] != 32'hFFFF_FFFF) ewc[k] = ewc[k] + 1;
          end else begin
            if (erc[k] != 32'hFFFF_FFFF) erc[k] = erc[k] + 1;
          end
        end else if (!pend[k] && en[k]) begin
          pend[k] = 1; acc[k] = cyc; lw[k] = wr[k];
          li[k] = int'((ad[k] >> 5) % 512); ld[k] = di[k];
        end
        if (pend[k] && cyc == acc[k] + lat_of(k) - 1) begin
          ea[k] = 1;
          if (!lw[k]) ed[k] = mm.exists(k * 1024 + li[k]) ? mm[k * 1024 + li[k]] : '0;
        end
      end
      eb[k] = pend[k];
    end
    cyc++;
  end

  // Every-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ack[%0d]", k),  256'(ack[k]),  256'(ea[k]));
        chk($sformatf("busy[%0d]", k), 256'(busy[k]), 256'(eb[k]));
        chk($sformatf("data[%0d]", k), dout[k], ed[k]);
        chk($sformatf("rcnt[%0d]", k), 256'(rcnt[k]), 256'(erc[k]));
        chk($sformatf("wcnt[%0d]", k), 256'(wcnt[k]), 256'(ewc[k]));
      end
    end
  end

  task automatic do_req(input int k, input logic w, input logic [31:0] a,
                        input logic [255:0] d, input bit scr,
                        output int lat, output logic [255:0] dat);
    int n;
    bit got;
    en[k] = 1'b1; wr[k] = w; ad[k] = a; di[k] = d;
    @(posedge clk); #1;
    if (scr) begin
      ad[k] = a ^ 32'h60;
      di[k] = ~d;
    end
    n = 0; got = 0; dat = '0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[k]) begin
        got = 1;
        dat = dout[k];
      end
    end
    chk("ack_seen", 256'(got), 256'(1));
    lat = n;
    @(posedge clk); #1;
    en[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int nack;
    logic [255:0] d;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    rst = 1'b1;
    en[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h60; di[0] = a5;
    en[1] = 1'b0; wr[1] = 1'b0; ad[1] = '0;     di[1] = '0;

    // Reset held with enable high.
    @(posedge clk); chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ack",  256'(ack[0]),  256'(0));
    chk("rst_busy", 256'(busy[0]), 256'(0));
    chk("rst_data", dout[0], '0);
    chk("rst_rcnt", 256'(rcnt[0]), 256'(0));
    chk("rst_wcnt", 256'(wcnt[0]), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Enable still high: accepted on the first edge after release (write A5 to line 3).
    do_req(0, 1'b1, 32'h60, a5, 0, lat, d);
    chk("wr_latency", 256'(lat), 256'(10));

    // Read latency.
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h60, '0, 0, lat, d);
    chk("rd_latency", 256'(lat), 256'(10));
    chk("rd_data",    d, a5);
    chk("rd_cnt1",    256'(rcnt[0]), 256'(1));

    // Write then read.
    do_req(0, 1'b1, 32'h80, 256'h1234, 0, lat, d);
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h80, '0, 0, lat, d);
    chk("wtr_data", d, 256'h1234);
    chk("wtr_wcnt", 256'(wcnt[0]), 256'(2));
    chk("wtr_rcnt", 256'(rcnt[0]), 256'(2));

    // Input stability during WAIT.
    do_req(0, 1'b1, 32'h40, 256'hBEEF, 0, lat, d);
    do_req(0, 1'b1, 32'h20, 256'hCAFE, 1, lat, d);
    do_req(0, 1'b0, 32'h20, '0, 0, lat, d);
    chk("stab_line1", d, 256'hCAFE);
    do_req(0, 1'b0, 32'h40, '0, 0, lat, d);
    chk("stab_line2", d, 256'hBEEF);

    // Reset in WAIT cycle 5 of a write to line 2.
    en[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h40; di[0] = 256'hDEAD;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; en[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    nack = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack[0]) nack++;
    end
    chk("abort_noack", 256'(nack), 256'(0));
    chk("abort_wcnt",  256'(wcnt[0]), 256'(0));
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h40, '0, 0, lat, d);
    chk("abort_keep", d, 256'hBEEF);
    chk("abort_rcnt", 256'(rcnt[0]), 256'(1));

    // LATENCY=1 build.
    do_req(1, 1'b1, 32'h0, 256'h77, 0, lat, d);
    chk("l1_wr_lat", 256'(lat), 256'(1));
    @(posedge clk); #1;
    do_req(1, 1'b0, 32'h0, '0, 0, lat, d);
    chk("l1_rd_lat",  256'(lat), 256'(1));
    chk("l1_rd_data", d, 256'h77);

    // Enable held: one accept every 2 cycles, 0x4000 aliases to line 0.
    @(posedge clk); #1;
    en[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'h4000;
    @(posedge clk);
    nack = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack[1]) begin
        nack++;
        chk($sformatf("l1_alias_data%0d", i), dout[1], 256'h77);
      end
    end
    en[1] = 1'b0;
    chk("l1_ack_count", 256'(nack), 256'(5));
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("l1_rcnt", 256'(rcnt[1]), 256'(6));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
